// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fetch FSM state enum, byte-to-word address shift, default reset
// PC and two small PC helpers used by the controller.
package inst_fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } fetch_state_e;

    // Byte PC to word index: the ROM is word addressed.
    localparam int unsigned WORD_SHIFT = 2;

    // PC used after reset when the instance does not override it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word index presented on mem_addr for a given byte PC.
    function automatic logic [31:0] word_index(input logic [31:0] pc);
        return pc >> WORD_SHIFT;
    endfunction

    // A PC with any of the low byte-offset bits set cannot be fetched.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[WORD_SHIFT-1:0] != '0;
    endfunction

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch_ctrl_if.sv
// Bundles the redirect input, the decode valid/ready channel, the ROM
// request channel and the fault flag of the fetch controller.
// Latency/backpressure: n/a (wiring only); decode backpressure is inst_ready.
//
// Signals:
//   redirect_valid/redirect_pc  new byte PC, flushes the buffer
//   inst_valid/inst_ready       word handshake toward decode
//   inst_data/inst_pc           fetched word and its byte PC
//   mem_cs/mem_addr             request strobe and word index to the ROM
//   mem_rdata/mem_stall         ROM return data and busy indication
//   fetch_err                   sticky misalignment/timeout fault
// Modports: master = fetch controller, slave = environment (ROM + decode).
interface inst_fetch_ctrl_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic        fetch_err;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  inst_ready,
        input  mem_rdata,
        input  mem_stall,
        output inst_valid,
        output inst_data,
        output inst_pc,
        output mem_cs,
        output mem_addr,
        output fetch_err
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        output inst_ready,
        output mem_rdata,
        output mem_stall,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        input  mem_cs,
        input  mem_addr,
        input  fetch_err
    );

endinterface : inst_fetch_ctrl_if

// File: rtl/inst_fetch_ctrl_timeout_cnt.sv
// Counts consecutive stalled request cycles and flags the last allowed one.
// Latency: count updates one cycle after i_inc; o_expired is decoded from the count register.
// Backpressure: none; clear has priority over increment.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_clr       return the count to zero
//   i_inc       add one (ignored while i_clr is high)
//   o_expired   count has reached TIMEOUT-1
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle that sees count==TIMEOUT-1 still stalled is the TIMEOUT-th
    // stalled request cycle, which is the one that gives up.
    assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule : fetch_timeout_cnt

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch initiator: one ROM word request at a time, one-entry output buffer to decode.
// Latency: ROM stall cycles + 1 from mem_cs rise to inst_valid; a mandatory 1-cycle idle gap between requests.
// Backpressure: a new request is issued only when the output buffer is empty or drains on that edge.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   fetch       inst_fetch_ctrl_if.master: redirect, decode handshake,
//               ROM request/return and the sticky fetch_err flag
// All outputs come straight from registers so a ROM that derives mem_stall
// combinationally from mem_cs cannot form a loop through this block.
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 64,
    parameter int          CNT_W    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_ctrl_if.master  fetch
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_mem_cs;
    logic [31:0]  r_mem_addr;
    logic         r_inst_valid;
    logic [31:0]  r_inst_data;
    logic [31:0]  r_inst_pc;
    logic         r_fetch_err;

    logic         w_cnt_clr;
    logic         w_cnt_inc;
    logic         w_cnt_expired;
    logic         w_drain;

    // Counter is held at zero outside REQ, so every request starts from a
    // fresh timeout budget.
    assign w_cnt_clr = (r_state != REQ);
    assign w_cnt_inc = (r_state == REQ) && !fetch.redirect_valid && fetch.mem_stall;

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_cnt_inc),
        .o_expired (w_cnt_expired)
    );

    // Decode takes the buffered word on this edge.
    assign w_drain = r_inst_valid && fetch.inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_mem_cs     <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_fetch_err  <= 1'b0;
        end else begin
            // Default buffer behaviour; a capture or a flush below overrides it.
            if (w_drain) begin
                r_inst_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (fetch.redirect_valid) begin
                        r_pc         <= fetch.redirect_pc;
                        r_inst_valid <= 1'b0;
                    end else if (is_misaligned(r_pc)) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= ERR;
                    end else if (!r_inst_valid || fetch.inst_ready) begin
                        // Buffer is empty or drains now, so the word this
                        // request returns can never overwrite unread data.
                        r_mem_cs   <= 1'b1;
                        r_mem_addr <= word_index(r_pc);
                        r_state    <= REQ;
                    end
                end

                REQ: begin
                    // mem_addr is left untouched here: the ROM restarts its
                    // access on any address change while mem_cs is high.
                    if (fetch.redirect_valid) begin
                        // Abandon the access; a word returned on this same
                        // edge belongs to the old stream and is dropped.
                        r_mem_cs     <= 1'b0;
                        r_pc         <= fetch.redirect_pc;
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end else if (!fetch.mem_stall) begin
                        r_inst_data  <= fetch.mem_rdata;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= r_pc + 32'd4;
                        r_mem_cs     <= 1'b0;
                        r_state      <= IDLE;
                    end else if (w_cnt_expired) begin
                        r_mem_cs    <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= ERR;
                    end
                end

                ERR: begin
                    // No requests; the buffer may still drain to decode.
                    if (fetch.redirect_valid) begin
                        r_fetch_err  <= 1'b0;
                        r_pc         <= fetch.redirect_pc;
                        r_inst_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end

                default: begin
                    r_mem_cs <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign fetch.mem_cs     = r_mem_cs;
    assign fetch.mem_addr   = r_mem_addr;
    assign fetch.inst_valid = r_inst_valid;
    assign fetch.inst_data  = r_inst_data;
    assign fetch.inst_pc    = r_inst_pc;
    assign fetch.fetch_err  = r_fetch_err;

endmodule : inst_fetch_ctrl

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: ROM model with programmable stall length,
// table-driven fetch vectors, directed redirect/timeout/misalign/wrap/reset
// sequences, and a randomized run against a transaction-level PC model.
module tb_inst_fetch_ctrl;

    logic clk;
    logic rst_n;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (64),
        .CNT_W    (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ROM contents as a function of the word index.
    function automatic logic [31:0] rom_word(input logic [31:0] widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- ROM model ----------------
    // Stalls for cur_lat cycles of each request, then returns the word. The
    // stall length is latched on the first cycle of every request.
    int lat_cfg  = 7;
    bit rand_lat = 1'b0;
    int age      = 0;
    int cur_lat  = 0;

    initial begin
        bus.mem_stall = 1'b0;
        bus.mem_rdata = 32'h0;
    end

    always begin
        @(posedge clk);
        #1;
        if (!bus.mem_cs) begin
            age = 0;
        end else begin
            age++;
            if (age == 1) cur_lat = rand_lat ? int'($urandom_range(0, 5)) : lat_cfg;
        end
        bus.mem_stall = bus.mem_cs && (age <= cur_lat);
        // Garbage while stalled so an early capture is visible.
        bus.mem_rdata = bus.mem_stall ? (32'hBAD0_0000 ^ 32'(age)) : rom_word(bus.mem_addr);
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cs(output int n);
        n = 0;
        while (!bus.mem_cs && n < 100) begin
            step();
            n++;
        end
        chk("wait_cs", 32'(bus.mem_cs), 32'd1);
    endtask

    // Counts cycles with mem_cs high, checking the address never moves.
    task automatic count_req(output int r);
        logic [31:0] a;
        a = bus.mem_addr;
        r = 0;
        while (bus.mem_cs && r < 200) begin
            chk("addr_stable", bus.mem_addr, a);
            step();
            r++;
        end
    endtask

    typedef struct {
        int unsigned stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        int unsigned exp_req;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int          gap;
        int          r;
        logic [31:0] held;
        bit          seen_cs;
        logic [31:0] pc_model;
        bit          hs;
        logic [31:0] hs_pc;
        logic [31:0] hs_data;
        bit          hold_pend;
        logic [31:0] hold_pc;
        logic [31:0] hold_data;
        bit          redir;
        logic [31:0] rpc;
        int          n_words;

        tbl[0] = '{stall: 7, exp_addr: 32'd0, exp_pc: 32'h00, exp_req: 8};
        tbl[1] = '{stall: 7, exp_addr: 32'd1, exp_pc: 32'h04, exp_req: 8};
        tbl[2] = '{stall: 7, exp_addr: 32'd2, exp_pc: 32'h08, exp_req: 8};
        tbl[3] = '{stall: 0, exp_addr: 32'd3, exp_pc: 32'h0C, exp_req: 1};

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;

        // ---- reset state ----
        step();
        step();
        chk("rst_mem_cs",     32'(bus.mem_cs), 32'd0);
        chk("rst_mem_addr",   bus.mem_addr, 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data",  bus.inst_data, 32'd0);
        chk("rst_inst_pc",    bus.inst_pc, 32'd0);
        chk("rst_fetch_err",  32'(bus.fetch_err), 32'd0);
        rst_n = 1'b1;

        // ---- table: sequential fetch from RESET_PC ----
        for (int i = 0; i < 4; i++) begin
            lat_cfg = int'(tbl[i].stall);
            wait_cs(gap);
            if (i > 0) chk("idle_gap", 32'(gap), 32'd1);
            chk("tbl_addr", bus.mem_addr, tbl[i].exp_addr);
            count_req(r);
            chk("tbl_req_cycles", 32'(r), 32'(tbl[i].exp_req));
            chk("tbl_valid", 32'(bus.inst_valid), 32'd1);
            chk("tbl_pc",    bus.inst_pc, tbl[i].exp_pc);
            chk("tbl_data",  bus.inst_data, rom_word(tbl[i].exp_addr));
        end

        // ---- decode backpressure on word 0x10 ----
        lat_cfg = 2;
        wait_cs(gap);
        chk("bp_addr", bus.mem_addr, 32'd4);
        count_req(r);
        chk("bp_pc", bus.inst_pc, 32'h10);
        bus.inst_ready = 1'b0;
        held = bus.inst_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("bp_hold_data",  bus.inst_data, held);
            chk("bp_no_req",     32'(bus.mem_cs), 32'd0);
        end
        lat_cfg = 7;
        bus.inst_ready = 1'b1;
        step();
        chk("bp_release_cs",    32'(bus.mem_cs), 32'd1);
        chk("bp_release_valid", 32'(bus.inst_valid), 32'd0);
        chk("bp_release_addr",  bus.mem_addr, 32'd5);

        // ---- redirect in the third stalled REQ cycle ----
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_cs_low", 32'(bus.mem_cs), 32'd0);
        chk("rd_valid",  32'(bus.inst_valid), 32'd0);
        step();
        chk("rd_cs_high", 32'(bus.mem_cs), 32'd1);
        chk("rd_addr",    bus.mem_addr, 32'h10);
        count_req(r);
        chk("rd_pc",   bus.inst_pc, 32'h40);
        chk("rd_data", bus.inst_data, rom_word(32'h10));

        // ---- redirect on the edge the ROM returns data ----
        lat_cfg = 3;
        wait_cs(gap);
        chk("rdr_addr", bus.mem_addr, 32'h11);
        step();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        step();
        bus.redirect_valid = 1'b0;
        chk("rdr_drop_valid", 32'(bus.inst_valid), 32'd0);
        chk("rdr_cs_low",     32'(bus.mem_cs), 32'd0);
        wait_cs(gap);
        chk("rdr_addr2", bus.mem_addr, 32'h20);
        count_req(r);
        chk("rdr_pc", bus.inst_pc, 32'h80);

        // ---- timeout ----
        lat_cfg = 1000000;
        wait_cs(gap);
        chk("to_addr", bus.mem_addr, 32'h21);
        count_req(r);
        chk("to_req_cycles", 32'(r), 32'd64);
        chk("to_err",        32'(bus.fetch_err), 32'd1);
        chk("to_cs",         32'(bus.mem_cs), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_err_sticky", 32'(bus.fetch_err), 32'd1);
            chk("to_no_req",     32'(bus.mem_cs), 32'd0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        chk("to_err_clear", 32'(bus.fetch_err), 32'd0);
        lat_cfg = 2;
        wait_cs(gap);
        chk("to_resume_addr", bus.mem_addr, 32'h0);
        count_req(r);
        chk("to_resume_pc", bus.inst_pc, 32'h0);

        // ---- misaligned redirect ----
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        step();
        bus.redirect_valid = 1'b0;
        chk("mis_valid_flush", 32'(bus.inst_valid), 32'd0);
        step();
        chk("mis_err", 32'(bus.fetch_err), 32'd1);
        seen_cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_cs |= bus.mem_cs;
            step();
        end
        chk("mis_no_req", 32'(seen_cs), 32'd0);

        // ---- PC wrap ----
        lat_cfg = 1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_err_clear", 32'(bus.fetch_err), 32'd0);
        wait_cs(gap);
        chk("wrap_addr_top", bus.mem_addr, 32'h3FFF_FFFF);
        count_req(r);
        chk("wrap_pc_top",   bus.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_data_top", bus.inst_data, rom_word(32'h3FFF_FFFF));
        wait_cs(gap);
        chk("wrap_addr_zero", bus.mem_addr, 32'h0);
        count_req(r);
        chk("wrap_pc_zero", bus.inst_pc, 32'h0);

        // ---- asynchronous reset mid-request ----
        lat_cfg = 10;
        wait_cs(gap);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cs",    32'(bus.mem_cs), 32'd0);
        chk("arst_addr",  bus.mem_addr, 32'd0);
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_pc",    bus.inst_pc, 32'd0);
        chk("arst_data",  bus.inst_data, 32'd0);
        chk("arst_err",   32'(bus.fetch_err), 32'd0);
        step();
        rst_n = 1'b1;
        wait_cs(gap);
        chk("arst_restart_addr", bus.mem_addr, 32'h0);

        // ---- randomized run against a transaction-level PC model ----
        // The model only knows: words reach decode in PC order, each accepted
        // word is pc_model, the next is pc_model+4, and a redirect restarts
        // the stream at the redirect PC. Any request must target pc_model.
        rand_lat           = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        pc_model  = 32'h100;
        hold_pend = 1'b0;
        hold_pc   = 32'h0;
        hold_data = 32'h0;
        n_words   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.mem_cs) chk("rnd_req_addr", bus.mem_addr, pc_model >> 2);
            if (hold_pend) begin
                chk("rnd_hold_valid", 32'(bus.inst_valid), 32'd1);
                chk("rnd_hold_pc",    bus.inst_pc, hold_pc);
                chk("rnd_hold_data",  bus.inst_data, hold_data);
            end
            chk("rnd_no_err", 32'(bus.fetch_err), 32'd0);

            bus.inst_ready     = ($urandom_range(0, 2) != 0);
            redir              = ($urandom_range(0, 40) == 0);
            rpc                = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bus.redirect_valid = redir;
            bus.redirect_pc    = rpc;

            hs        = bus.inst_valid && bus.inst_ready;
            hs_pc     = bus.inst_pc;
            hs_data   = bus.inst_data;
            hold_pend = bus.inst_valid && !bus.inst_ready && !redir;
            hold_pc   = bus.inst_pc;
            hold_data = bus.inst_data;

            step();

            if (hs) begin
                chk("rnd_word_pc",   hs_pc, pc_model);
                chk("rnd_word_data", hs_data, rom_word(pc_model >> 2));
                pc_model = pc_model + 32'd4;
                n_words++;
            end
            if (redir) pc_model = rpc;
        end
        bus.redirect_valid = 1'b0;
        chk("rnd_progress", 32'(n_words >= 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl
